mem_arbiter: RTL

- Shares one single-port unified word memory between the instruction-fetch stage (IF port) and the load/store stage (DM port) of the MIPS pipeline.
- Owns the arbitration state machine, the access-latency counter and the response registers.
- Returns per-port ready pulses; the pipeline uses them to stall.
- Sits between the IF/MEM stages and the memory array.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_lat_cnt.sv | 44 ++++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified-memory arbiter.
//   state_e      : arbiter FSM encoding (IDLE / ACCESS / RESP)
//   OWN_IF/OWN_DM: grant owner codes
//   CNT_W        : width of the access-latency down-counter
//   lat_load_val : value loaded into the counter on a grant
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int CNT_W = 4;

    // The counter reaches zero in the last access cycle, so it starts at
    // latency-1.
    function automatic logic [CNT_W-1:0] lat_load_val(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_lat_cnt
// Loadable down-counter that times one memory access.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i (takes precedence over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : counter currently equals zero
// -----------------------------------------------------------------------------
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port word memory between the instruction-fetch port (IF)
// and the load/store port (DM). One access at a time: IDLE -> ACCESS
// (MEM_LATENCY cycles) -> RESP (one-cycle ready pulse) -> IDLE.
//
// Handshake: a port raises *_req and holds it, with stable address/data,
// until its *_ready pulse; *_ready is high for exactly one cycle and *_rdata
// is valid only in that cycle (0 otherwise, 0 for stores). Address, write
// enable and write data are latched at grant.
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   if_req/if_addr          : fetch request and byte address
//   if_rdata/if_ready       : fetched word and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request (we=1 store)
//   dm_rdata/dm_ready       : load data and completion pulse
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
//   dbg_state               : current FSM state, for observation
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise DM always wins over IF.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    state_e            state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              mem_ce_q;
    logic              mem_we_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;

    logic grant_if;
    logic grant_dm;
    logic cnt_zero;

    // Byte-lane bits are never used: the memory is word-addressed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;
`endif

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (dm_req && if_req) begin
                // Contention: favour whichever port did not win last time.
                grant_dm = (last_grant_q == OWN_IF);
                grant_if = (last_grant_q == OWN_DM);
            end else begin
                grant_dm = dm_req;
                grant_if = if_req;
            end
`else
            // The load/store is the older instruction, so it wins.
            grant_dm = dm_req;
            grant_if = if_req & ~dm_req;
`endif
        end
    end

    mem_arb_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (grant_if | grant_dm),
        .load_val_i (lat_load_val(MEM_LATENCY)),
        .dec_i      (state_q == ACCESS),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= OWN_IF;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_dm) begin
                        owner_q  <= OWN_DM;
                        addr_q   <= {dm_addr[ADDR_W-1:2], 2'b00};
                        wdata_q  <= dm_wdata;
                        mem_we_q <= dm_we;
                        mem_ce_q <= 1'b1;
                        state_q  <= ACCESS;
`ifdef MEM_ARB_RR_EN
                        last_grant_q <= OWN_DM;
`endif
                    end else if (grant_if) begin
                        owner_q  <= OWN_IF;
                        addr_q   <= {if_addr[ADDR_W-1:2], 2'b00};
                        wdata_q  <= '0;
                        mem_we_q <= 1'b0;
                        mem_ce_q <= 1'b1;
                        state_q  <= ACCESS;
`ifdef MEM_ARB_RR_EN
                        last_grant_q <= OWN_IF;
`endif
                    end
                end
                ACCESS: begin
                    // mem_rdata is sampled in the last access cycle.
                    if (cnt_zero) begin
                        mem_ce_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= RESP;
                        if (owner_q == OWN_DM) begin
                            dm_ready_q <= 1'b1;
                            dm_rdata_q <= mem_we_q ? 32'h0 : mem_rdata;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    if_ready_q <= 1'b0;
                    dm_ready_q <= 1'b0;
                    if_rdata_q <= '0;
                    dm_rdata_q <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign dbg_state = state_q;

endmodule
